// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared types and constants for the serial BCD adder controller.
//  Revision : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam int BCD_CORR    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_add
//  Purpose  : Combinational single-digit BCD adder with decimal carry.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] da_i,
    input  logic [BCD_DIGIT_W-1:0] db_i,
    input  logic                   ci_i,
    output logic [BCD_DIGIT_W-1:0] digit_o,
    output logic                   co_o
);

    logic [BCD_DIGIT_W:0] w_sum;
    logic [BCD_DIGIT_W:0] w_sum_corr;

    assign w_sum      = {1'b0, da_i} + {1'b0, db_i} + {{BCD_DIGIT_W{1'b0}}, ci_i};
    assign w_sum_corr = w_sum + (BCD_DIGIT_W+1)'(BCD_CORR);
    assign co_o       = (w_sum > (BCD_DIGIT_W+1)'(BCD_MAX));
    // Non-BCD inputs still follow the same rule; only the low nibble survives.
    assign digit_o    = co_o ? w_sum_corr[BCD_DIGIT_W-1:0] : w_sum[BCD_DIGIT_W-1:0];

endmodule : bcd_digit_add
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_serial_add_ctrl
//  Purpose  : Digit-serial N-digit BCD adder with valid/ready on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                          cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout,
    output logic                          err,
    output logic                          busy
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   carry_q;
    logic [W-1:0]           a_q;
    logic [W-1:0]           b_q;
    logic [W-1:0]           sum_q;
    logic                   cout_q;
    logic                   err_q;
    logic                   out_valid_q;

    logic [BCD_DIGIT_W-1:0] w_digit;
    logic                   w_dc;
    logic                   w_bad;
    logic [W+BCD_DIGIT_W-1:0] w_sum_cat;
    logic [W-1:0]           sum_d;

    bcd_digit_add u_digit_add (
        .da_i    (a_q[BCD_DIGIT_W-1:0]),
        .db_i    (b_q[BCD_DIGIT_W-1:0]),
        .ci_i    (carry_q),
        .digit_o (w_digit),
        .co_o    (w_dc)
    );

    // New digits enter at the top so the LS digit ends up at the bottom after DIGITS shifts.
    assign w_sum_cat = {w_digit, sum_q};
    assign sum_d     = w_sum_cat[W+BCD_DIGIT_W-1:BCD_DIGIT_W];

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX)) ||
                (b[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX))) begin
                w_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        err_q   <= w_bad;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q   <= sum_d;
                    a_q     <= a_q >> BCD_DIGIT_W;
                    b_q     <= b_q >> BCD_DIGIT_W;
                    carry_q <= w_dc;
                    if (cnt_q == CNT_LAST) begin
                        cout_q      <= w_dc;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == ADD) || (state_q == DONE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule : bcd_serial_add_ctrl
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_serial_add_ctrl
//  Purpose  : Self-checking bench for the digit-serial BCD adder controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_serial_add_ctrl;

    localparam int DIG = 4;
    localparam int W   = 4 * DIG;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    logic         busy;

    bcd_serial_add_ctrl #(.DIGITS(DIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic [W-1:0] es, input logic ec, input logic ee);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.sum = es; e.cout = ec; e.err = ee;
        sb.push_back(e);
        check("busy_after_accept", 64'(busy), 64'd1);
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
    endtask

    // Starts #1 after the accept edge; counts edges until out_valid.
    task automatic collect(input int hold, input bit poke);
        int   k;
        exp_t e;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", 64'(k), 64'(DIG));
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            e.sum = '0; e.cout = 1'b0; e.err = 1'b0;
        end else begin
            e = sb.pop_front();
        end
        check("sum", 64'(sum), 64'(e.sum));
        check("cout", 64'(cout), 64'(e.cout));
        check("err", 64'(err), 64'(e.err));
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 2) begin
                a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("hold_sum", 64'(sum), 64'(e.sum));
            check("hold_cout", 64'(cout), 64'(e.cout));
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_back", 64'(in_ready), 64'd1);
        check("busy_clear", 64'(busy), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[4] = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[5] = '{16'h4567, 16'h4433, 1'b0, 16'h9000, 1'b0, 1'b0};
        vecs[6] = '{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1};
        vecs[7] = '{16'h0000, 16'hF000, 1'b0, 16'h5000, 1'b1, 1'b1};
        vecs[8] = '{16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0};

        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].err);
            collect(0, 1'b0);
        end

        // Back-pressure in DONE with an in_valid poke that must be ignored.
        send(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        collect(6, 1'b1);

        // Reset during the second ADD cycle discards the operation.
        send(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_pulse", 64'(out_valid), 64'd0);
        send(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);
        collect(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bcd_serial_add_ctrl
`default_nettype wire
